// File: rtl/word_stream_tx_if.sv
// Word-in / byte-out handshake bundle for word_stream_tx.
// The slave side is the serializer; the master side is the word source and UART.
interface word_stream_tx_if #(
    parameter int WORD_BYTES = 4
);
    logic                    in_valid;
    logic [8*WORD_BYTES-1:0] in_word;
    logic                    in_ready;
    logic                    tx_start;
    logic [7:0]              tx_data;
    logic                    tx_busy;

    modport slave (
        input  in_valid, in_word, tx_busy,
        output in_ready, tx_start, tx_data
    );

    modport master (
        output in_valid, in_word, tx_busy,
        input  in_ready, tx_start, tx_data
    );
endinterface

// File: rtl/word_stream_tx.sv
// Serializes a captured word into a framed byte stream for a UART transmitter.
// Frame: optional sync byte, data bytes in configured order, optional XOR checksum.
//
// state     | meaning
// IDLE      | waiting for a word; in_ready high from the second IDLE cycle on
// LOAD      | captured word compared against last-sent word; skip or start frame
// START     | tx_start high for one cycle with tx_data valid
// WAIT_ACK  | waiting for tx_busy to rise
// WAIT_DONE | waiting for tx_busy to fall; advance index or finish frame
module word_stream_tx #(
    parameter int         WORD_BYTES  = 4,
    parameter bit         MSB_FIRST   = 1'b1,
    parameter bit         SYNC_EN     = 1'b1,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter bit         CHK_EN      = 1'b1,
    parameter bit         SKIP_REPEAT = 1'b1
) (
    input  logic            sysclk,
    input  logic            rst_n,
    word_stream_tx_if.slave bus,
    output logic            frame_done,
    output logic [7:0]      skip_cnt
);
    localparam int         WORD_W    = 8 * WORD_BYTES;
    localparam int         SYNC_N    = SYNC_EN ? 1 : 0;
    localparam int         CHK_N     = CHK_EN ? 1 : 0;
    localparam int         FRAME_LEN = SYNC_N + WORD_BYTES + CHK_N;
    localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);
    localparam logic [3:0] WB_L      = 4'(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   hold_q;
    logic [WORD_W-1:0]   last_q;
    logic                last_vld_q;
    logic                in_ready_q;
    logic                tx_start_q;
    logic [7:0]          tx_data_q;
    logic                frame_done_q;
    logic [7:0]          skip_cnt_q;
    logic [3:0]          idx_q;

    logic [3:0]          idx_d;
    logic [3:0]          data_idx;
    logic [3:0]          byte_pos;
    logic [WORD_W-1:0]   shifted;
    logic [7:0]          chk;
    logic [7:0]          sel_byte;

    // Index of the byte about to be launched: 0 out of LOAD, next one out of WAIT_DONE.
    assign idx_d    = (state_q == WAIT_DONE) ? idx_q + 4'd1 : 4'd0;
    assign data_idx = idx_d - 4'(SYNC_N);
    assign byte_pos = MSB_FIRST ? (WB_L - 4'd1 - data_idx) : data_idx;
    assign shifted  = hold_q >> {byte_pos, 3'b000};

    always_comb begin
        chk = 8'h00;
        for (int i = 0; i < WORD_BYTES; i++) begin
            chk = chk ^ hold_q[8*i +: 8];
        end
    end

    always_comb begin
        sel_byte = chk;
        if (SYNC_EN && idx_d == 4'd0) begin
            sel_byte = SYNC_BYTE;
        end else if (data_idx < WB_L) begin
            sel_byte = shifted[7:0];
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            last_q       <= '0;
            last_vld_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            skip_cnt_q   <= 8'h00;
            idx_q        <= 4'd0;
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // in_ready stays low for the first IDLE cycle so a new transfer
                    // can never coincide with frame_done or a skip return.
                    if (in_ready_q && bus.in_valid) begin
                        hold_q     <= bus.in_word;
                        in_ready_q <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (SKIP_REPEAT && last_vld_q && hold_q == last_q) begin
                        if (skip_cnt_q != 8'hFF) begin
                            skip_cnt_q <= skip_cnt_q + 8'd1;
                        end
                        state_q <= IDLE;
                    end else begin
                        idx_q      <= idx_d;
                        tx_data_q  <= sel_byte;
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (idx_q == LAST_IDX) begin
                            frame_done_q <= 1'b1;
                            last_q       <= hold_q;
                            last_vld_q   <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            idx_q      <= idx_d;
                            tx_data_q  <= sel_byte;
                            tx_start_q <= 1'b1;
                            state_q    <= START;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign frame_done   = frame_done_q;
    assign skip_cnt     = skip_cnt_q;
endmodule

// File: tb/tb_word_stream_tx.sv
// Bench for word_stream_tx: two configurations checked cycle by cycle against a
// frame-level model, plus directed scenarios pinned with literal byte sequences.
`timescale 1ns/1ps
module tb_word_stream_tx;
    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       fd0, fd1;
    logic [7:0] sc0, sc1;

    always #5 sysclk = ~sysclk;

    word_stream_tx_if #(.WORD_BYTES(4)) bus0 ();
    word_stream_tx_if #(.WORD_BYTES(4)) bus1 ();

    word_stream_tx dut0 (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .bus        (bus0),
        .frame_done (fd0),
        .skip_cnt   (sc0)
    );

    word_stream_tx #(
        .WORD_BYTES (4),
        .MSB_FIRST  (1'b0),
        .SYNC_EN    (1'b0),
        .CHK_EN     (1'b0)
    ) dut1 (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .bus        (bus1),
        .frame_done (fd1),
        .skip_cnt   (sc1)
    );

    localparam logic [7:0] E35 [6] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    localparam logic [7:0] E36 [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Frame-level model: instance 0 = sync+MSB-first+checksum, instance 1 = bare LSB-first.
    logic [7:0]  fb [2][10];
    int          flen [2];
    int          fpos [2];
    bit          inflight [2];
    bit          acked [2];
    bit          is_last [2];
    logic [7:0]  cur [2];
    bit          last_v [2];
    logic [31:0] last_w [2];
    bit          was_rst [2] = '{1'b1, 1'b1};
    int          start_at [2];
    int          done_at [2];
    int          ready_at [2];
    int          skip_at [2];
    int          skip_exp [2];
    int          start_n [2] = '{0, 0};
    int          done_n [2] = '{0, 0};
    logic [7:0]  log_b [2][16];
    int          log_n [2] = '{0, 0};

    int          ack_dly [2] = '{0, 0};
    int          busy_len [2] = '{20, 20};
    bit          rand_uart [2] = '{1'b0, 1'b0};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic build_frame(input int k, input logic [31:0] w);
        logic [7:0] b;
        logic [7:0] x;
        int         sh;
        x       = 8'h00;
        flen[k] = 0;
        if (k == 0) begin
            fb[k][0] = 8'hA5;
            flen[k]  = 1;
        end
        for (int i = 0; i < 4; i++) begin
            sh = (k == 0) ? 8 * (3 - i) : 8 * i;
            b  = 8'((w >> sh) & 32'hFF);
            x  = x ^ b;
            fb[k][flen[k]] = b;
            flen[k]++;
        end
        if (k == 0) begin
            fb[k][flen[k]] = x;
            flen[k]++;
        end
        fpos[k] = 0;
    endtask

    task automatic mon(input int k, input logic rdy, input logic vld, input logic [31:0] word,
                       input logic st, input logic [7:0] data, input logic busy,
                       input logic fd, input logic [7:0] sc);
        bit exp_rdy;
        if (rst_n !== 1'b1) begin
            check("reset_in_ready", rdy, 0);
            check("reset_tx_start", st, 0);
            check("reset_tx_data", data, 8'h00);
            check("reset_frame_done", fd, 0);
            check("reset_skip_cnt", sc, 0);
            fpos[k] = 0; flen[k] = 0; inflight[k] = 0; acked[k] = 0;
            last_v[k] = 0; skip_exp[k] = 0; was_rst[k] = 1;
            start_at[k] = -1; done_at[k] = -1; ready_at[k] = -1; skip_at[k] = -1;
            return;
        end
        if (was_rst[k]) begin
            was_rst[k]  = 0;
            ready_at[k] = cyc + 1;
        end
        if (cyc == skip_at[k] && skip_exp[k] < 255) skip_exp[k]++;
        exp_rdy = (ready_at[k] >= 0) && (cyc >= ready_at[k]);
        check("in_ready", rdy, exp_rdy);
        check("tx_start", st, cyc == start_at[k]);
        check("frame_done", fd, cyc == done_at[k]);
        check("skip_cnt", sc, skip_exp[k]);
        if (st) start_n[k]++;
        if (fd) done_n[k]++;
        if (st && cyc == start_at[k]) begin
            check("tx_data", data, fb[k][fpos[k]]);
            cur[k] = fb[k][fpos[k]];
            if (log_n[k] < 16) begin
                log_b[k][log_n[k]] = data;
                log_n[k]++;
            end
            fpos[k]++;
            is_last[k]  = (fpos[k] == flen[k]);
            inflight[k] = 1;
            acked[k]    = 0;
            start_at[k] = -1;
        end else if (inflight[k]) begin
            check("tx_data_hold", data, cur[k]);
            if (busy) begin
                acked[k] = 1;
            end else if (acked[k]) begin
                inflight[k] = 0;
                if (is_last[k]) begin
                    done_at[k]  = cyc + 1;
                    ready_at[k] = cyc + 2;
                end else begin
                    start_at[k] = cyc + 1;
                end
            end
        end
        if (vld && exp_rdy) begin
            ready_at[k] = -1;
            if (last_v[k] && word == last_w[k]) begin
                skip_at[k]  = cyc + 2;
                ready_at[k] = cyc + 3;
            end else begin
                build_frame(k, word);
                last_w[k]   = word;
                last_v[k]   = 1;
                start_at[k] = cyc + 2;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge sysclk);
            cyc++;
            mon(0, bus0.in_ready, bus0.in_valid, bus0.in_word, bus0.tx_start, bus0.tx_data,
                bus0.tx_busy, fd0, sc0);
            mon(1, bus1.in_ready, bus1.in_valid, bus1.in_word, bus1.tx_start, bus1.tx_data,
                bus1.tx_busy, fd1, sc1);
        end
    end

    task automatic set_busy(input int k, input logic v);
        if (k == 0) bus0.tx_busy = v;
        else        bus1.tx_busy = v;
    endtask

    // UART stand-in: busy rises (1 + ack delay) cycles after tx_start, holds busy_len cycles.
    task automatic uart(input int k);
        forever begin
            @(negedge sysclk);
            if (((k == 0) ? bus0.tx_start : bus1.tx_start) === 1'b1 && rst_n === 1'b1) begin
                int a;
                int b;
                a = rand_uart[k] ? int'($urandom_range(0, 3)) : ack_dly[k];
                b = rand_uart[k] ? int'($urandom_range(1, 6)) : busy_len[k];
                repeat (a + 1) @(posedge sysclk);
                #1 set_busy(k, 1'b1);
                repeat (b) @(posedge sysclk);
                #1 set_busy(k, 1'b0);
            end
        end
    endtask

    initial uart(0);
    initial uart(1);

    task automatic set_in(input int k, input logic v, input logic [31:0] w);
        if (k == 0) begin bus0.in_valid = v; bus0.in_word = w; end
        else        begin bus1.in_valid = v; bus1.in_word = w; end
    endtask

    task automatic send(input int k, input logic [31:0] w);
        bit ok;
        ok = 0;
        @(posedge sysclk);
        #1 set_in(k, 1'b1, w);
        for (int i = 0; i < 2000; i++) begin
            @(negedge sysclk);
            ok = (k == 0) ? bus0.in_ready : bus1.in_ready;
            @(posedge sysclk);
            #1;
            if (ok) break;
        end
        set_in(k, 1'b0, w);
        check("send_accepted", ok, 1);
    endtask

    task automatic wait_done(input int k, input int target);
        for (int i = 0; i < 3000; i++) begin
            @(posedge sysclk);
            if (done_n[k] >= target) break;
        end
        check("frame_done_reached", done_n[k] >= target, 1);
    endtask

    initial begin
        int          base_s;
        int          base_d;
        int          k;
        logic [31:0] w;

        rst_n = 1'b0;
        set_in(0, 1'b0, 32'h0);
        set_in(1, 1'b0, 32'h0);
        bus0.tx_busy = 1'b0;
        bus1.tx_busy = 1'b0;
        repeat (3) @(posedge sysclk);
        #1 check("por_in_ready_low", bus0.in_ready, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 check("ready_after_release", bus0.in_ready, 1);

        // Default configuration, 20-cycle busy.
        base_s = start_n[0]; base_d = done_n[0]; log_n[0] = 0;
        send(0, 32'h11223344);
        wait_done(0, base_d + 1);
        repeat (3) @(posedge sysclk);
        check("frame_starts", start_n[0] - base_s, 6);
        check("frame_dones", done_n[0] - base_d, 1);
        check("frame_len_logged", log_n[0], 6);
        for (int i = 0; i < 6; i++) check("default_byte", log_b[0][i], E35[i]);

        // LSB-first, no sync, no checksum.
        busy_len[1] = 3;
        base_s = start_n[1]; base_d = done_n[1]; log_n[1] = 0;
        send(1, 32'hDEADBEEF);
        wait_done(1, base_d + 1);
        repeat (3) @(posedge sysclk);
        check("lsb_starts", start_n[1] - base_s, 4);
        for (int i = 0; i < 4; i++) check("lsb_byte", log_b[1][i], E36[i]);

        // Repeat suppression, then a differing word.
        busy_len[0] = 3;
        base_s = start_n[0];
        send(0, 32'h11223344);
        repeat (6) @(posedge sysclk);
        #1 check("skip_no_start", start_n[0] - base_s, 0);
        check("skip_cnt_one", sc0, 8'd1);
        base_d = done_n[0]; log_n[0] = 0;
        send(0, 32'h11223345);
        wait_done(0, base_d + 1);
        check("chk_byte_45", log_b[0][5], 8'h45);

        // in_valid held with a changing word across several frames.
        @(posedge sysclk);
        #1 set_in(0, 1'b1, $urandom);
        for (int i = 0; i < 150; i++) begin
            @(posedge sysclk);
            #1 set_in(0, 1'b1, $urandom);
        end
        set_in(0, 1'b0, 32'h0);
        repeat (60) @(posedge sysclk);

        // Reset while waiting for byte 3 to complete.
        busy_len[0] = 20;
        base_s = start_n[0];
        send(0, 32'h11223344);
        for (int i = 0; i < 500; i++) begin
            @(posedge sysclk);
            if (start_n[0] >= base_s + 4) break;
        end
        check("reached_byte3", start_n[0] >= base_s + 4, 1);
        repeat (3) @(posedge sysclk);
        #3 rst_n = 1'b0;
        #1;
        check("async_in_ready", bus0.in_ready, 0);
        check("async_tx_start", bus0.tx_start, 0);
        check("async_tx_data", bus0.tx_data, 8'h00);
        check("async_frame_done", fd0, 0);
        check("async_skip_cnt", sc0, 8'h00);
        repeat (30) @(posedge sysclk);
        #1 rst_n = 1'b1;
        busy_len[0] = 3;
        base_d = done_n[0]; log_n[0] = 0;
        send(0, 32'h11223345);
        wait_done(0, base_d + 1);
        check("resend_len", log_n[0], 6);
        check("resend_chk", log_b[0][5], 8'h45);
        check("resend_skip_cnt", sc0, 8'h00);

        // Saturation of skip_cnt.
        for (int i = 0; i < 300; i++) send(0, 32'h11223345);
        repeat (6) @(posedge sysclk);
        #1 check("skip_saturated", sc0, 8'd255);

        // Randomized traffic on both instances with random UART timing.
        rand_uart[0] = 1'b1;
        rand_uart[1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 1));
            w = ($urandom_range(0, 3) == 0) ? last_w[k] : $urandom;
            send(k, w);
            repeat ($urandom_range(0, 3)) @(posedge sysclk);
        end
        repeat (200) @(posedge sysclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
